// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for PLL lock supervision: state encoding and default timing
// derived from the reference clock frequency.
`default_nettype none

package pll_lock_supervisor_pkg;

  localparam int REF_CLK_HZ         = 16_000_000;
  localparam int PLL_RST_CYCLES_DEF = 16;
  localparam int LOCK_TIMEOUT_DEF   = REF_CLK_HZ / 1_000;   // 1 ms
  localparam int STABLE_CYCLES_DEF  = REF_CLK_HZ / 10_000;  // 100 us
  localparam int MAX_RETRIES_DEF    = 3;
  localparam int CNT_W_DEF          = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs; both stages reset to 0.
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// Drives PLL RESETB, debounces the asynchronous LOCK, gates the core reset on a
// proven-stable lock, retries on timeout and counts lock losses while running.
`default_nettype none

module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int MAX_RETRIES    = MAX_RETRIES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  output logic             pll_resetb,
  output logic             sys_reset,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       retry_count
);

  localparam int TMR_MAX = max_int(max_int(LOCK_TIMEOUT, STABLE_CYCLES), PLL_RST_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);

  logic lock_s;

  sup_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle wins: no retry is charged.
        if (lock_s) begin
          state_d = STABLE;
        end else if (timer_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (int'(retry_inc) >= MAX_RETRIES) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STB_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        timer_d = '0;
        if (!lock_s) begin
          state_d = PLL_RST;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
      end
      FAULT: begin
        timer_d = '0;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // Outputs follow the next state so they change on the transition edge itself.
    pll_resetb_d = (state_d != PLL_RST) && (state_d != FAULT);
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PLL_RST;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// Directed/randomized bench for pll_lock_supervisor; expectations come from timing arithmetic.
`default_nettype none

module tb_pll_lock_supervisor;

  localparam int P = 16;   // PLL reset pulse length
  localparam int T = 400;  // lock timeout
  localparam int S = 50;   // stable window
  localparam int R = 3;    // retries before fault
  localparam int W = 8;    // loss counter width

  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic         locked = 1'b0;
  logic         pll_resetb, sys_reset, ready, fault;
  logic [W-1:0] loss_count;
  logic [1:0]   retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (P),
    .LOCK_TIMEOUT   (T),
    .STABLE_CYCLES  (S),
    .MAX_RETRIES    (R),
    .CNT_W          (W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .locked      (locked),
    .pll_resetb  (pll_resetb),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fault       (fault),
    .loss_count  (loss_count),
    .retry_count (retry_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Number of consecutive observations (from now) where pll_resetb == v.
  task automatic seg_len(input logic v, input int budget, output int n);
    n = 0;
    while (pll_resetb === v && n < budget) begin
      n++;
      step();
    end
  endtask

  // Steps until ready is seen high, bounded by budget.
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ready !== 1'b1 && n < budget);
  endtask

  // One lock-loss event while running, followed by re-lock back into RUN.
  task automatic do_loss(input int k);
    int n;
    repeat ($urandom_range(0, 5)) step();
    locked = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (sys_reset !== 1'b1 && n < 10);
    check("loss_detect_cycles", n, 3);
    check("loss_ready_low", ready, 0);
    check("loss_count", loss_count, (k > 255) ? 255 : k);
    repeat ($urandom_range(4, 12)) step();
    locked = 1'b1;
    wait_ready(P + S + 40, n);
    check("relock_ready", ready, 1);
    check("relock_retry", retry_count, 0);
  endtask

  initial begin
    int n, d, g;

    // Reset state
    reset = 1'b1; locked = 1'b0;
    step(); step();
    check("rst_pll_resetb", pll_resetb, 0);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_loss", loss_count, 0);
    check("rst_retry", retry_count, 0);
    reset = 1'b0;

    // Nominal lock
    seg_len(1'b0, 100, n);
    check("nom_pll_rst_len", n, P);
    d = $urandom_range(20, 100);
    repeat (d) step();
    check("nom_sysrst_before_lock", sys_reset, 1);
    locked = 1'b1;
    wait_ready(S + 20, n);
    check("nom_lock_to_ready", n, S + 3);
    check("nom_sys_reset_low", sys_reset, 0);
    check("nom_loss", loss_count, 0);
    check("nom_retry", retry_count, 0);

    // Five losses, then reset while running
    for (int i = 1; i <= 5; i++) do_loss(i);
    check("pre_rst_ready", ready, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrun_pll_resetb", pll_resetb, 0);
    check("midrun_sys_reset", sys_reset, 1);
    check("midrun_ready", ready, 0);
    check("midrun_loss", loss_count, 0);
    wait_ready(P + S + 40, n);
    check("midrun_relock_time", n, P + 1 + S);

    // Saturating loss counter
    for (int i = 1; i <= 300; i++) do_loss(i);
    check("loss_saturated", loss_count, 255);

    // Glitch in STABLE
    reset = 1'b1; locked = 1'b0;
    step();
    reset = 1'b0;
    seg_len(1'b0, 100, n);
    check("glitch_pll_rst_len", n, P);
    repeat ($urandom_range(5, 30)) step();
    locked = 1'b1;
    g = $urandom_range(8, S - 10);
    repeat (g) step();
    check("glitch_not_ready_yet", ready, 0);
    locked = 1'b0;
    step();
    locked = 1'b1;
    wait_ready(S + 20, n);
    check("glitch_restart_time", n, S + 3);
    check("glitch_retry", retry_count, 0);

    // Timeout and retry into FAULT
    reset = 1'b1; locked = 1'b0;
    step();
    reset = 1'b0;
    for (int a = 1; a <= R; a++) begin
      seg_len(1'b0, P + 10, n);
      check("to_low_len", n, P);
      check("to_retry", retry_count, a - 1);
      seg_len(1'b1, T + 10, n);
      check("to_high_len", n, T);
    end
    check("fault_set", fault, 1);
    check("fault_pll_resetb", pll_resetb, 0);
    check("fault_retry", retry_count, 3);
    repeat (50) step();
    check("fault_sticky", fault, 1);
    check("fault_pll_held", pll_resetb, 0);
    check("fault_sys_reset", sys_reset, 1);
    check("fault_ready", ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("fault_cleared", fault, 0);
    check("fault_retry_cleared", retry_count, 0);

    // Lock arriving exactly on the timeout cycle (after one genuine timeout)
    seg_len(1'b0, P + 10, n);
    check("sim_low_len", n, P);
    seg_len(1'b1, T + 10, n);
    check("sim_first_timeout", n, T);
    seg_len(1'b0, P + 10, n);
    check("sim_low_len2", n, P);
    check("sim_retry_before", retry_count, 1);
    repeat (T - 3) step();
    locked = 1'b1;
    step(); step(); step();
    check("sim_no_retry_reset", pll_resetb, 1);
    check("sim_retry_unchanged", retry_count, 1);
    wait_ready(S + 10, n);
    check("sim_stable_to_run", n, S);
    check("sim_retry_cleared", retry_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
